// File: rtl/tx_fifo.sv
// Transmit FIFO feeding a machine's din. Capacity is DEPTH words, or 2*DEPTH when joined.
// Pushes and pops may share a cycle. Overflow and underflow are sticky, write-1-to-clear flags.
module tx_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         join_i,
    input  logic                         flush,
    input  logic                         wr,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pull,
    input  logic                         pull_en,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(2*DEPTH):0]     level,
    output logic                         overflow,
    output logic                         underflow,
    input  logic [1:0]                   clr_flags
);

    localparam int CAP2 = 2 * DEPTH;
    localparam int PW   = $clog2(CAP2);
    localparam int LW   = $clog2(CAP2) + 1;

    logic [WIDTH-1:0] mem [CAP2];

    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [LW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          joinHist_q;
    logic          joinSeen_q;

    logic [LW-1:0] capacity;
    logic [LW-1:0] lastIdx;
    logic          joinChange;
    logic          flushNow;
    logic          popOk;
    logic          pushOk;

    // joinSeen_q keeps the first cycle after reset from reading as a mode change,
    // so the history register never needs an asynchronous load of join_i.
    assign capacity   = join_i ? LW'(CAP2) : LW'(DEPTH);
    assign lastIdx    = capacity - LW'(1);
    assign joinChange = joinSeen_q && (join_i != joinHist_q);
    assign flushNow   = flush || joinChange;

    assign empty = (level_q == '0);
    assign full  = (level_q == capacity);
    assign level = level_q;
    assign dout  = empty ? '0 : mem[rdPtr_q];

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    assign popOk  = pull && pull_en && !empty && !flushNow;
    assign pushOk = wr && (!full || popOk) && !flushNow;

    always_comb begin
        rdPtr_d     = rdPtr_q;
        wrPtr_d     = wrPtr_q;
        level_d     = level_q;
        overflow_d  = overflow_q && !clr_flags[0];
        underflow_d = underflow_q && !clr_flags[1];

        if (flushNow) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            level_d = '0;
            overflow_d  = overflow_q;
            underflow_d = underflow_q;
        end else begin
            if (pushOk)
                wrPtr_d = ({1'b0, wrPtr_q} == lastIdx) ? '0 : wrPtr_q + PW'(1);
            if (popOk)
                rdPtr_d = ({1'b0, rdPtr_q} == lastIdx) ? '0 : rdPtr_q + PW'(1);
            if (pushOk && !popOk)
                level_d = level_q + LW'(1);
            else if (popOk && !pushOk)
                level_d = level_q - LW'(1);
            // A flag's set condition takes priority over its clear bit.
            if (wr && full && !popOk)
                overflow_d = 1'b1;
            if (pull && pull_en && empty)
                underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtr_q     <= '0;
            wrPtr_q     <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            joinHist_q  <= 1'b0;
            joinSeen_q  <= 1'b0;
        end else begin
            rdPtr_q     <= rdPtr_d;
            wrPtr_q     <= wrPtr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            joinHist_q  <= join_i;
            joinSeen_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (pushOk)
            mem[wrPtr_q] <= wdata;
    end

endmodule
